// File: rtl/rtc_time_core.sv
`default_nettype none
// ============================================================================
// Module      : rtc_time_core
// Description : RTC calendar/time counter. Loads validated INIT_* fields on
//               a load strobe, advances sec..year on each enabled 1 Hz tick,
//               and emits registered per-unit rollover strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_core #(
  parameter int YEAR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [5:0]        init_sec_i,
  input  logic [5:0]        init_min_i,
  input  logic [6:0]        init_hours_i,
  input  logic [2:0]        init_dow_i,
  input  logic [4:0]        init_dom_i,
  input  logic [3:0]        init_month_i,
  input  logic [YEAR_W-1:0] init_year_i,
  output logic [5:0]        cur_sec_o,
  output logic [5:0]        cur_min_o,
  output logic [6:0]        cur_hours_o,
  output logic [2:0]        cur_dow_o,
  output logic [4:0]        cur_dom_o,
  output logic [3:0]        cur_month_o,
  output logic [YEAR_W-1:0] cur_year_o,
  output logic              sec_strb_o,
  output logic              min_strb_o,
  output logic              hour_strb_o,
  output logic              day_strb_o,
  output logic              year_wrap_o,
  output logic              load_err_o
);

  localparam logic [YEAR_W-1:0] c_YEAR_MAX = YEAR_W'(99);

  // Year is offset from 2000, so every year divisible by 4 in range is leap.
  function automatic logic [4:0] f_days_in_month(input logic [3:0] month,
                                                 input logic [1:0] year_lsb);
    logic [4:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = (year_lsb == 2'd0) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  // Current time state; hours are split into value, 12 h mode and PM flag.
  logic [5:0]        r_sec;
  logic [5:0]        r_min;
  logic [4:0]        r_hr;
  logic              r_mode;
  logic              r_pm;
  logic [2:0]        r_dow;
  logic [4:0]        r_dom;
  logic [3:0]        r_month;
  logic [YEAR_W-1:0] r_year;
  logic              r_sec_strb;
  logic              r_min_strb;
  logic              r_hour_strb;
  logic              r_day_strb;
  logic              r_year_wrap;
  logic              r_load_err;

  // Load validation
  logic [4:0] w_init_hr;
  logic       w_init_mode;
  logic       w_init_pm;
  logic [4:0] w_init_dim;
  logic       w_hr_ok;
  logic       w_load_ok;

  assign w_init_hr   = init_hours_i[4:0];
  assign w_init_mode = init_hours_i[5];
  assign w_init_pm   = init_hours_i[6];
  assign w_init_dim  = f_days_in_month(init_month_i, init_year_i[1:0]);

  assign w_hr_ok = w_init_mode ? ((w_init_hr >= 5'd1) && (w_init_hr <= 5'd12))
                               : ((w_init_hr <= 5'd23) && !w_init_pm);

  assign w_load_ok = (init_sec_i <= 6'd59) && (init_min_i <= 6'd59) && w_hr_ok &&
                     (init_dow_i != 3'd0) &&
                     (init_month_i >= 4'd1) && (init_month_i <= 4'd12) &&
                     (init_year_i <= c_YEAR_MAX) &&
                     (init_dom_i >= 5'd1) && (init_dom_i <= w_init_dim);

  // Next-state values for one accepted tick
  logic [5:0]        w_nxt_sec;
  logic [5:0]        w_nxt_min;
  logic [4:0]        w_nxt_hr;
  logic              w_nxt_pm;
  logic [2:0]        w_nxt_dow;
  logic [4:0]        w_nxt_dom;
  logic [3:0]        w_nxt_month;
  logic [YEAR_W-1:0] w_nxt_year;
  logic              w_min_roll;
  logic              w_hour_roll;
  logic              w_day_roll;
  logic              w_year_roll;
  logic [4:0]        w_cur_dim;

  assign w_cur_dim = f_days_in_month(r_month, r_year[1:0]);

  // Cascade seconds -> minutes -> hours -> calendar for a single tick.
  always_comb begin
    w_nxt_sec   = r_sec;
    w_nxt_min   = r_min;
    w_nxt_hr    = r_hr;
    w_nxt_pm    = r_pm;
    w_nxt_dow   = r_dow;
    w_nxt_dom   = r_dom;
    w_nxt_month = r_month;
    w_nxt_year  = r_year;
    w_min_roll  = 1'b0;
    w_hour_roll = 1'b0;
    w_day_roll  = 1'b0;
    w_year_roll = 1'b0;

    if (r_sec == 6'd59) begin
      w_nxt_sec  = 6'd0;
      w_min_roll = 1'b1;
      if (r_min == 6'd59) begin
        w_nxt_min   = 6'd0;
        w_hour_roll = 1'b1;
        if (!r_mode) begin
          if (r_hr == 5'd23) begin
            w_nxt_hr   = 5'd0;
            w_day_roll = 1'b1;
          end else begin
            w_nxt_hr = r_hr + 5'd1;
          end
        end else begin
          // 12 h clock reads 12,1..11; the meridian flips on 11->12 and a
          // new day starts only when that flip goes from PM to AM.
          if (r_hr == 5'd12) begin
            w_nxt_hr = 5'd1;
          end else if (r_hr == 5'd11) begin
            w_nxt_hr   = 5'd12;
            w_nxt_pm   = ~r_pm;
            w_day_roll = r_pm;
          end else begin
            w_nxt_hr = r_hr + 5'd1;
          end
        end
      end else begin
        w_nxt_min = r_min + 6'd1;
      end
    end else begin
      w_nxt_sec = r_sec + 6'd1;
    end

    if (w_day_roll) begin
      w_nxt_dow = (r_dow == 3'd7) ? 3'd1 : (r_dow + 3'd1);
      if (r_dom == w_cur_dim) begin
        w_nxt_dom = 5'd1;
        if (r_month == 4'd12) begin
          w_nxt_month = 4'd1;
          if (r_year == c_YEAR_MAX) begin
            w_nxt_year  = '0;
            w_year_roll = 1'b1;
          end else begin
            w_nxt_year = r_year + YEAR_W'(1);
          end
        end else begin
          w_nxt_month = r_month + 4'd1;
        end
      end else begin
        w_nxt_dom = r_dom + 5'd1;
      end
    end
  end

  // Time registers: load has priority and swallows a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec       <= 6'd0;
      r_min       <= 6'd0;
      r_hr        <= 5'd0;
      r_mode      <= 1'b0;
      r_pm        <= 1'b0;
      r_dow       <= 3'd1;
      r_dom       <= 5'd1;
      r_month     <= 4'd1;
      r_year      <= '0;
      r_sec_strb  <= 1'b0;
      r_min_strb  <= 1'b0;
      r_hour_strb <= 1'b0;
      r_day_strb  <= 1'b0;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sec_strb  <= 1'b0;
      r_min_strb  <= 1'b0;
      r_hour_strb <= 1'b0;
      r_day_strb  <= 1'b0;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
      if (load_i) begin
        if (w_load_ok) begin
          r_sec   <= init_sec_i;
          r_min   <= init_min_i;
          r_hr    <= w_init_hr;
          r_mode  <= w_init_mode;
          r_pm    <= w_init_pm;
          r_dow   <= init_dow_i;
          r_dom   <= init_dom_i;
          r_month <= init_month_i;
          r_year  <= init_year_i;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (tick_i && en_i) begin
        r_sec       <= w_nxt_sec;
        r_min       <= w_nxt_min;
        r_hr        <= w_nxt_hr;
        r_pm        <= w_nxt_pm;
        r_dow       <= w_nxt_dow;
        r_dom       <= w_nxt_dom;
        r_month     <= w_nxt_month;
        r_year      <= w_nxt_year;
        r_sec_strb  <= 1'b1;
        r_min_strb  <= w_min_roll;
        r_hour_strb <= w_hour_roll;
        r_day_strb  <= w_day_roll;
        r_year_wrap <= w_year_roll;
      end
    end
  end

  assign cur_sec_o   = r_sec;
  assign cur_min_o   = r_min;
  assign cur_hours_o = {r_pm, r_mode, r_hr};
  assign cur_dow_o   = r_dow;
  assign cur_dom_o   = r_dom;
  assign cur_month_o = r_month;
  assign cur_year_o  = r_year;
  assign sec_strb_o  = r_sec_strb;
  assign min_strb_o  = r_min_strb;
  assign hour_strb_o = r_hour_strb;
  assign day_strb_o  = r_day_strb;
  assign year_wrap_o = r_year_wrap;
  assign load_err_o  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_time_core
// Description : Directed self-checking bench for rtc_time_core with an
//               expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_core;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [6:0] hours;
    logic [2:0] dow;
    logic [4:0] dom;
    logic [3:0] month;
    logic [6:0] year;
  } tm_t;

  typedef struct {
    tm_t        t;
    logic [5:0] st;   // {sec, min, hour, day, year_wrap, load_err}
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic       tick_i;
  logic       load_i;
  logic [5:0] init_sec_i;
  logic [5:0] init_min_i;
  logic [6:0] init_hours_i;
  logic [2:0] init_dow_i;
  logic [4:0] init_dom_i;
  logic [3:0] init_month_i;
  logic [6:0] init_year_i;
  logic [5:0] cur_sec_o;
  logic [5:0] cur_min_o;
  logic [6:0] cur_hours_o;
  logic [2:0] cur_dow_o;
  logic [4:0] cur_dom_o;
  logic [3:0] cur_month_o;
  logic [6:0] cur_year_o;
  logic       sec_strb_o;
  logic       min_strb_o;
  logic       hour_strb_o;
  logic       day_strb_o;
  logic       year_wrap_o;
  logic       load_err_o;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  tm_t        cur;
  logic [5:0] st;
  assign cur = {cur_sec_o, cur_min_o, cur_hours_o, cur_dow_o, cur_dom_o, cur_month_o, cur_year_o};
  assign st  = {sec_strb_o, min_strb_o, hour_strb_o, day_strb_o, year_wrap_o, load_err_o};

  rtc_time_core #(.YEAR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .tick_i(tick_i), .load_i(load_i),
    .init_sec_i(init_sec_i), .init_min_i(init_min_i), .init_hours_i(init_hours_i),
    .init_dow_i(init_dow_i), .init_dom_i(init_dom_i), .init_month_i(init_month_i),
    .init_year_i(init_year_i),
    .cur_sec_o(cur_sec_o), .cur_min_o(cur_min_o), .cur_hours_o(cur_hours_o),
    .cur_dow_o(cur_dow_o), .cur_dom_o(cur_dom_o), .cur_month_o(cur_month_o),
    .cur_year_o(cur_year_o),
    .sec_strb_o(sec_strb_o), .min_strb_o(min_strb_o), .hour_strb_o(hour_strb_o),
    .day_strb_o(day_strb_o), .year_wrap_o(year_wrap_o), .load_err_o(load_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tm_t mk(input int s, input int m, input int h, input int dw,
                             input int dm, input int mo, input int y);
    tm_t t;
    t.sec   = 6'(s);
    t.min   = 6'(m);
    t.hours = 7'(h);
    t.dow   = 3'(dw);
    t.dom   = 5'(dm);
    t.month = 4'(mo);
    t.year  = 7'(y);
    return t;
  endfunction

  task automatic compare(input tm_t et, input logic [5:0] est, input string tag);
    checks++;
    assert (cur === et) else begin
      failures++;
      $error("FAIL %s time observed=%h expected=%h", tag, cur, et);
    end
    checks++;
    assert (st === est) else begin
      failures++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, st, est);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then pop and
  // compare once the registered outputs have updated.
  task automatic step(input logic ld, input logic tk, input logic en, input tm_t init,
                      input tm_t et, input logic [5:0] est, input string tag);
    exp_t e;
    @(negedge clk);
    load_i = ld;
    tick_i = tk;
    en_i   = en;
    {init_sec_i, init_min_i, init_hours_i, init_dow_i,
     init_dom_i, init_month_i, init_year_i} = init;
    e.t = et; e.st = est; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load_i = 1'b0;
    tick_i = 1'b0;
    e = sb.pop_front();
    compare(e.t, e.st, e.tag);
  endtask

  tm_t rst_t, a, b, l;

  initial begin
    rst_t = mk(0, 0, 0, 1, 1, 1, 0);
    rst_n = 1'b0; en_i = 1'b0; tick_i = 1'b0; load_i = 1'b0;
    {init_sec_i, init_min_i, init_hours_i, init_dow_i,
     init_dom_i, init_month_i, init_year_i} = '0;
    #12;
    compare(rst_t, 6'b0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Century rollover: every strobe fires once
    a = mk(59, 59, 23, 7, 31, 12, 99);
    step(1, 0, 1, a, a, 6'b000000, "load_y99");
    step(0, 1, 1, a, mk(0, 0, 0, 1, 1, 1, 0), 6'b111110, "tick_y99");
    step(0, 0, 1, a, mk(0, 0, 0, 1, 1, 1, 0), 6'b000000, "idle_y99");

    // Leap and non-leap February
    a = mk(59, 59, 23, 3, 28, 2, 24);
    step(1, 0, 1, a, a, 6'b000000, "load_feb24");
    step(0, 1, 1, a, mk(0, 0, 0, 4, 29, 2, 24), 6'b111100, "tick_feb24");
    a = mk(59, 59, 23, 3, 28, 2, 23);
    step(1, 0, 1, a, a, 6'b000000, "load_feb23");
    step(0, 1, 1, a, mk(0, 0, 0, 4, 1, 3, 23), 6'b111100, "tick_feb23");

    // 12 h mode
    a = mk(59, 59, 'h6B, 2, 10, 5, 25);
    step(1, 0, 1, a, a, 6'b000000, "load_1159pm");
    step(0, 1, 1, a, mk(0, 0, 'h2C, 3, 11, 5, 25), 6'b111100, "tick_1159pm");
    a = mk(59, 59, 'h6C, 2, 10, 5, 25);
    step(1, 0, 1, a, a, 6'b000000, "load_1259pm");
    step(0, 1, 1, a, mk(0, 0, 'h61, 2, 10, 5, 25), 6'b111000, "tick_1259pm");
    a = mk(59, 59, 'h2B, 2, 10, 5, 25);
    step(1, 0, 1, a, a, 6'b000000, "load_1159am");
    step(0, 1, 1, a, mk(0, 0, 'h6C, 2, 10, 5, 25), 6'b111000, "tick_1159am");

    // Load wins over a coincident tick; disabled ticks are ignored
    l = mk(30, 20, 10, 3, 15, 6, 24);
    step(1, 1, 1, l, l, 6'b000000, "load_and_tick");
    for (int i = 0; i < 5; i++) step(0, 1, 0, l, l, 6'b000000, "tick_disabled");
    step(0, 1, 1, l, mk(31, 20, 10, 3, 15, 6, 24), 6'b100000, "tick_plain");
    l = mk(31, 20, 10, 3, 15, 6, 24);

    // Rejected loads leave time untouched
    step(1, 0, 1, mk(0, 60, 10, 3, 15, 6, 24), l, 6'b000001, "err_min60");
    step(1, 0, 1, mk(0, 0, 24, 3, 15, 6, 24), l, 6'b000001, "err_hr24");
    step(1, 0, 1, mk(0, 0, 10, 3, 31, 4, 24), l, 6'b000001, "err_apr31");
    step(1, 0, 1, mk(0, 0, 'h20, 3, 15, 6, 24), l, 6'b000001, "err_12h_hr0");
    step(1, 0, 1, mk(0, 0, 'h4A, 3, 15, 6, 24), l, 6'b000001, "err_24h_pm");
    step(1, 0, 1, mk(0, 0, 10, 3, 29, 2, 23), l, 6'b000001, "err_feb29_y23");
    step(1, 0, 1, mk(0, 0, 10, 0, 15, 6, 24), l, 6'b000001, "err_dow0");
    step(0, 0, 1, l, l, 6'b000000, "idle_after_err");

    // Asynchronous reset after 100 ticks
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      tick_i = 1'b1;
      en_i   = 1'b1;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
    end
    b = mk(0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 1, b, mk(40, 1, 0, 1, 1, 1, 0), 6'b100000, "tick100");
    #2;
    rst_n = 1'b0;
    #1;
    compare(rst_t, 6'b0, "async_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
